sram_bus_slave: RTL and testbench

SRAM_BUS_SLAVE -- requirements
Module: sram_bus_slave

---
 rtl/bus_pkg.sv | 20 ++
 rtl/sram_bus_slave.sv | 169 ++++++++++++++++
 tb/tb_sram_bus_slave.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: definitions shared by the bus responders and the DMA controllers.
// It holds the responder state encoding and the bus-level constants.
package bus_pkg;

  localparam int WORD_BYTES       = 4;
  localparam int MAX_BURST        = 256;
  localparam int BYTE_OFFSET_BITS = $clog2(WORD_BYTES);
  // One extra bit so that a full MAX_BURST-word burst fits in the count.
  localparam int COUNT_BITS       = $clog2(MAX_BURST) + 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    READ_DATA,
    WRITE_DATA,
    END,
    ERROR
  } bus_state_e;

endpackage

// File: rtl/sram_bus_slave.sv
// sram_bus_slave: bus responder that maps a 2^ADDR_BITS x 32 synchronous SRAM
// (1-cycle read latency) at BASE_ADDRESS. It handles read and write bursts and
// refuses bursts that would run past the last SRAM word.
module sram_bus_slave
  import bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
  parameter int          ADDR_BITS    = 9
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          busIn_address_data,
  input  logic [7:0]           busIn_burst_size,
  input  logic                 busIn_read_n_write,
  input  logic                 busIn_begin_transaction,
  input  logic                 busIn_end_transaction,
  input  logic                 busIn_data_valid,
  input  logic                 busIn_busy,
  input  logic                 busIn_error,
  input  logic [3:0]           busIn_byte_enable,
  output logic [31:0]          busOut_address_data,
  output logic                 busOut_end_transaction,
  output logic                 busOut_data_valid,
  output logic                 busOut_busy,
  output logic                 busOut_error,
  output logic [ADDR_BITS-1:0] sram_address,
  output logic                 sram_write_enable,
  output logic [3:0]           sram_byte_enable,
  output logic [31:0]          sram_data,
  input  logic [31:0]          sram_result
);

  // Address bits above the word index select this responder's window.
  localparam int                    TAG_LSB    = ADDR_BITS + BYTE_OFFSET_BITS;
  localparam logic [ADDR_BITS-1:0]  LAST_INDEX = '1;
  localparam logic [ADDR_BITS-1:0]  INDEX_ONE  = ADDR_BITS'(1);
  localparam logic [COUNT_BITS-1:0] COUNT_ONE  = COUNT_BITS'(1);

  bus_state_e            r_state, w_next_state;
  logic [ADDR_BITS-1:0]  r_index, w_next_index;
  logic [COUNT_BITS-1:0] r_count, w_next_count;
  logic [3:0]            r_byte_en, w_next_byte_en;

  logic w_in_range;
  logic w_at_last;
  logic w_last_word;
  logic w_abort;

  assign w_in_range  = (busIn_address_data[31:TAG_LSB] == BASE_ADDRESS[31:TAG_LSB]);
  assign w_at_last   = (r_index == LAST_INDEX);
  assign w_last_word = (r_count == COUNT_ONE);
  // Reset or an initiator error kills the current cycle's activity outright.
  assign w_abort     = reset || (busIn_error && (r_state != IDLE));

  // The responder never stalls the initiator.
  assign busOut_busy = 1'b0;

  // State and latched burst fields advance on the clock; reset is synchronous.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (reset) begin
      r_state   <= IDLE;
      r_index   <= '0;
      r_count   <= '0;
      r_byte_en <= '0;
    end else begin
      r_state   <= w_next_state;
      r_index   <= w_next_index;
      r_count   <= w_next_count;
      r_byte_en <= w_next_byte_en;
    end
  end

  // Next-state, next-field and output decode for the burst FSM.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    w_next_state           = r_state;
    w_next_index           = r_index;
    w_next_count           = r_count;
    w_next_byte_en         = r_byte_en;
    busOut_address_data    = '0;
    busOut_end_transaction = 1'b0;
    busOut_data_valid      = 1'b0;
    busOut_error           = 1'b0;
    sram_address           = r_index;
    sram_write_enable      = 1'b0;
    sram_byte_enable       = '0;
    sram_data              = '0;

    unique case (r_state)
      IDLE: begin
        if (busIn_begin_transaction && w_in_range) begin
          w_next_index   = busIn_address_data[TAG_LSB-1:BYTE_OFFSET_BITS];
          w_next_count   = COUNT_BITS'(busIn_burst_size) + COUNT_ONE;
          w_next_byte_en = busIn_byte_enable;
          w_next_state   = busIn_read_n_write ? READ_WAIT : WRITE_DATA;
        end
      end

      // The SRAM samples r_index at the end of this cycle.
      READ_WAIT: w_next_state = READ_DATA;

      READ_DATA: begin
        busOut_data_valid   = 1'b1;
        busOut_address_data = sram_result;
        // While stalled, the default re-presents r_index so the word repeats.
        if (!busIn_busy) begin
          w_next_count = r_count - COUNT_ONE;
          if (w_last_word) begin
            w_next_state = END;
          end else if (w_at_last) begin
            w_next_state = ERROR;
          end else begin
            w_next_index = r_index + INDEX_ONE;
            sram_address = r_index + INDEX_ONE;
          end
        end
      end

      WRITE_DATA: begin
        if (busIn_data_valid) begin
          sram_write_enable = 1'b1;
          sram_byte_enable  = r_byte_en;
          sram_data         = busIn_address_data;
          w_next_count      = r_count - COUNT_ONE;
          if (w_last_word) begin
            w_next_state = IDLE;
          end else if (w_at_last) begin
            w_next_state = ERROR;
          end else begin
            w_next_index = r_index + INDEX_ONE;
          end
        end
        // An initiator-terminated write closes silently.
        if (busIn_end_transaction) begin
          w_next_state = IDLE;
        end
      end

      END: begin
        busOut_end_transaction = 1'b1;
        w_next_state           = IDLE;
      end

      ERROR: begin
        busOut_error           = 1'b1;
        busOut_end_transaction = 1'b1;
        w_next_state           = IDLE;
      end

      default: w_next_state = IDLE;
    endcase

    if (w_abort) begin
      w_next_state           = IDLE;
      busOut_address_data    = '0;
      busOut_end_transaction = 1'b0;
      busOut_data_valid      = 1'b0;
      busOut_error           = 1'b0;
      sram_address           = '0;
      sram_write_enable      = 1'b0;
      sram_byte_enable       = '0;
      sram_data              = '0;
    end
  end

endmodule

// File: tb/tb_sram_bus_slave.sv
// tb_sram_bus_slave: directed self-checking bench for sram_bus_slave with a
// behavioural sram_512x32 model built in.
module tb_sram_bus_slave;

  localparam logic [31:0] BASE = 32'h5000_0000;
  localparam int          AB   = 9;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] busIn_address_data;
  logic [7:0]  busIn_burst_size;
  logic        busIn_read_n_write;
  logic        busIn_begin_transaction;
  logic        busIn_end_transaction;
  logic        busIn_data_valid;
  logic        busIn_busy;
  logic        busIn_error;
  logic [3:0]  busIn_byte_enable;
  logic [31:0] busOut_address_data;
  logic        busOut_end_transaction;
  logic        busOut_data_valid;
  logic        busOut_busy;
  logic        busOut_error;
  logic [AB-1:0] sram_address;
  logic        sram_write_enable;
  logic [3:0]  sram_byte_enable;
  logic [31:0] sram_data;
  logic [31:0] sram_result;

  // Backdoor preload port of the SRAM model.
  logic          pre_we;
  logic [AB-1:0] pre_addr;
  logic [31:0]   pre_data;

  logic [31:0] mem [0:(1<<AB)-1];

  int n_cmp;
  int n_err;

  always #5 clock = ~clock;

  sram_bus_slave #(
    .BASE_ADDRESS(BASE),
    .ADDR_BITS   (AB)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .busIn_address_data     (busIn_address_data),
    .busIn_burst_size       (busIn_burst_size),
    .busIn_read_n_write     (busIn_read_n_write),
    .busIn_begin_transaction(busIn_begin_transaction),
    .busIn_end_transaction  (busIn_end_transaction),
    .busIn_data_valid       (busIn_data_valid),
    .busIn_busy             (busIn_busy),
    .busIn_error            (busIn_error),
    .busIn_byte_enable      (busIn_byte_enable),
    .busOut_address_data    (busOut_address_data),
    .busOut_end_transaction (busOut_end_transaction),
    .busOut_data_valid      (busOut_data_valid),
    .busOut_busy            (busOut_busy),
    .busOut_error           (busOut_error),
    .sram_address           (sram_address),
    .sram_write_enable      (sram_write_enable),
    .sram_byte_enable       (sram_byte_enable),
    .sram_data              (sram_data),
    .sram_result            (sram_result)
  );

  // sram_512x32 model: byte-enabled write, registered read (1-cycle latency).
  always @(posedge clock) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (sram_write_enable) begin
      for (int b = 0; b < 4; b++) begin
        if (sram_byte_enable[b]) mem[sram_address][8*b +: 8] <= sram_data[8*b +: 8];
      end
    end
    sram_result <= mem[sram_address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_idle();
    busIn_address_data      = '0;
    busIn_burst_size        = '0;
    busIn_read_n_write      = 1'b0;
    busIn_begin_transaction = 1'b0;
    busIn_end_transaction   = 1'b0;
    busIn_data_valid        = 1'b0;
    busIn_busy              = 1'b0;
    busIn_error             = 1'b0;
    busIn_byte_enable       = '0;
  endtask

  task automatic begin_txn(input logic [31:0] addr, input logic [7:0] burst,
                           input logic rnw, input logic [3:0] be);
    busIn_address_data      = addr;
    busIn_burst_size        = burst;
    busIn_read_n_write      = rnw;
    busIn_byte_enable       = be;
    busIn_begin_transaction = 1'b1;
  endtask

  task automatic preload(input int a, input logic [31:0] d);
    pre_we   = 1'b1;
    pre_addr = AB'(a);
    pre_data = d;
    step();
    pre_we   = 1'b0;
  endtask

  // All responder-driven bus signals packed for one quiet-bus comparison.
  function automatic logic [31:0] bus_out_or();
    return busOut_address_data |
           {28'd0, busOut_data_valid, busOut_end_transaction, busOut_error, busOut_busy};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          beats;
    logic        busy_pat [7];
    logic [31:0] data_pat [7];
    n_cmp  = 0;
    n_err  = 0;
    pre_we = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    bus_idle();
    reset = 1'b1;
    step();
    step();

    // Reset state.
    @(negedge clock);
    check("rst bus_out", bus_out_or(), 32'd0);
    check("rst sram_we", 32'(sram_write_enable), 32'd0);
    check("rst sram_addr", 32'(sram_address), 32'd0);
    check("rst sram_be", 32'(sram_byte_enable), 32'd0);
    check("rst sram_data", sram_data, 32'd0);
    step();
    reset = 1'b0;
    @(negedge clock);
    check("post-rst bus_out", bus_out_or(), 32'd0);
    check("post-rst sram_addr", 32'(sram_address), 32'd0);
    step();

    for (int i = 0; i < 4; i++) preload(i, 32'hA0 + 32'(i));
    preload(4, 32'hAAAA_BBBB);
    preload(5, 32'hCCCC_DDDD);
    preload(8, 32'h0);
    preload(9, 32'h0);
    preload(511, 32'hDEAD_BEEF);

    // Read burst of 4 words, no stalls.
    begin_txn(BASE, 8'd3, 1'b1, 4'hF);
    @(negedge clock);
    check("rd1 idle valid", 32'(busOut_data_valid), 32'd0);
    step();
    bus_idle();
    @(negedge clock);
    check("rd1 wait valid", 32'(busOut_data_valid), 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check($sformatf("rd1 beat%0d valid", i), 32'(busOut_data_valid), 32'd1);
      check($sformatf("rd1 beat%0d data", i), busOut_address_data, 32'hA0 + 32'(i));
      check($sformatf("rd1 beat%0d end", i), 32'(busOut_end_transaction), 32'd0);
      step();
    end
    @(negedge clock);
    check("rd1 end pulse", 32'(busOut_end_transaction), 32'd1);
    check("rd1 end valid", 32'(busOut_data_valid), 32'd0);
    step();
    @(negedge clock);
    check("rd1 after end", bus_out_or(), 32'd0);
    step();

    // Read burst with the second beat stalled for 3 cycles.
    busy_pat = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    data_pat = '{32'hA0, 32'hA1, 32'hA1, 32'hA1, 32'hA1, 32'hA2, 32'hA3};
    beats = 0;
    begin_txn(BASE, 8'd3, 1'b1, 4'hF);
    step();
    bus_idle();
    step();
    for (int i = 0; i < 7; i++) begin
      busIn_busy = busy_pat[i];
      @(negedge clock);
      check($sformatf("rd2 cyc%0d valid", i), 32'(busOut_data_valid), 32'd1);
      check($sformatf("rd2 cyc%0d data", i), busOut_address_data, data_pat[i]);
      if (busOut_data_valid && !busIn_busy) beats++;
      step();
    end
    busIn_busy = 1'b0;
    check("rd2 unique beats", 32'(beats), 32'd4);
    @(negedge clock);
    check("rd2 end pulse", 32'(busOut_end_transaction), 32'd1);
    step();
    @(negedge clock);
    check("rd2 after end", bus_out_or(), 32'd0);
    step();

    // Write burst of 2 words with lower-half byte enables.
    begin_txn(BASE + 32'h10, 8'd1, 1'b0, 4'b0011);
    step();
    bus_idle();
    busIn_data_valid   = 1'b1;
    busIn_address_data = 32'h1122_3344;
    @(negedge clock);
    check("wr w0 we", 32'(sram_write_enable), 32'd1);
    check("wr w0 addr", 32'(sram_address), 32'd4);
    check("wr w0 be", 32'(sram_byte_enable), 32'h3);
    check("wr w0 data", sram_data, 32'h1122_3344);
    step();
    busIn_address_data = 32'h5566_7788;
    @(negedge clock);
    check("wr w1 we", 32'(sram_write_enable), 32'd1);
    check("wr w1 addr", 32'(sram_address), 32'd5);
    step();
    busIn_address_data = 32'hFFFF_FFFF;
    @(negedge clock);
    check("wr extra dropped", 32'(sram_write_enable), 32'd0);
    check("wr no end", 32'(busOut_end_transaction), 32'd0);
    step();
    bus_idle();
    check("wr mem4", mem[4], 32'hAAAA_3344);
    check("wr mem5", mem[5], 32'hCCCC_7788);

    // Read burst starting at the last word: one beat, then an error pulse.
    begin_txn(BASE + 32'h7FC, 8'd1, 1'b1, 4'hF);
    step();
    bus_idle();
    step();
    @(negedge clock);
    check("bnd beat valid", 32'(busOut_data_valid), 32'd1);
    check("bnd beat data", busOut_address_data, 32'hDEAD_BEEF);
    check("bnd beat err", 32'(busOut_error), 32'd0);
    step();
    @(negedge clock);
    check("bnd error pulse", 32'(busOut_error), 32'd1);
    check("bnd end pulse", 32'(busOut_end_transaction), 32'd1);
    check("bnd no valid", 32'(busOut_data_valid), 32'd0);
    step();
    @(negedge clock);
    check("bnd idle", bus_out_or(), 32'd0);
    step();

    // Out-of-range begin produces no response.
    begin_txn(BASE + 32'h800, 8'd0, 1'b1, 4'hF);
    step();
    bus_idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check($sformatf("oor cyc%0d", i), bus_out_or(), 32'd0);
      step();
    end

    // Initiator error aborts a read in its first data beat.
    begin_txn(BASE, 8'd3, 1'b1, 4'hF);
    step();
    bus_idle();
    step();
    busIn_error = 1'b1;
    @(negedge clock);
    check("abort quiet", bus_out_or(), 32'd0);
    step();
    busIn_error = 1'b0;
    @(negedge clock);
    check("abort idle", bus_out_or(), 32'd0);
    step();

    // Reset during the second beat of a 4-word write.
    begin_txn(BASE + 32'h20, 8'd3, 1'b0, 4'hF);
    step();
    bus_idle();
    busIn_data_valid   = 1'b1;
    busIn_address_data = 32'h0101_0101;
    @(negedge clock);
    check("rstw w0 we", 32'(sram_write_enable), 32'd1);
    check("rstw w0 addr", 32'(sram_address), 32'd8);
    step();
    busIn_address_data = 32'h0202_0202;
    reset = 1'b1;
    @(negedge clock);
    check("rstw w1 suppressed", 32'(sram_write_enable), 32'd0);
    check("rstw w1 bus", bus_out_or(), 32'd0);
    step();
    reset = 1'b0;
    busIn_address_data = 32'h0303_0303;
    @(negedge clock);
    check("rstw next we", 32'(sram_write_enable), 32'd0);
    check("rstw next bus", bus_out_or(), 32'd0);
    check("rstw next addr", 32'(sram_address), 32'd0);
    check("rstw next be", 32'(sram_byte_enable), 32'd0);
    check("rstw next data", sram_data, 32'd0);
    step();
    bus_idle();
    check("rstw mem8", mem[8], 32'h0101_0101);
    check("rstw mem9", mem[9], 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
